// File: rtl/uart_ctrl_v2.sv
// uart_ctrl_v2: bus-mapped UART with RX/TX FIFOs, programmable divisor, sticky RX errors and level IRQ.
// Optional feature macro UART_LOOPBACK_EN: CTRL[4] routes the internal TX line into RX and parks tx_sig high.
module uart_ctrl_v2 #(
  parameter int ClockFreqHz  = 10000000,
  parameter int BaudRate     = 115200,
  parameter int DataBitsSize = 8,
  parameter int StopBitsSize = 1,
  parameter int RxDepth      = 16,
  parameter int TxDepth      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_sig,
  output logic       tx_sig,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] data,
  input  logic       addr_strobe,
  output logic       irq
);
  localparam int DB  = DataBitsSize;
  localparam int RAW = $clog2(RxDepth);
  localparam int TAW = $clog2(TxDepth);
  localparam logic [15:0] DivRst  = 16'(ClockFreqHz / BaudRate);
  localparam logic [2:0]  LastBit = 3'(DB - 1);
`ifdef UART_LOOPBACK_EN
  localparam logic [4:0]  CtrlMask = 5'h1F;
`else
  localparam logic [4:0]  CtrlMask = 5'h0F;
`endif

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [15:0] div_q, div_d, eff_div;
  logic [4:0]  ctrl_q, ctrl_d;
  logic [7:0]  data_q, data_d, rd_val, status;
  logic        overrun_q, overrun_d, frame_err_q, frame_err_d, irq_q, irq_d;
  logic        sel_stat, sel_rxd, sel_txd, lpbk;

  logic [DB-1:0]  rx_mem [RxDepth];
  logic [RAW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [RAW:0]   rxf_cnt_q, rxf_cnt_d;
  logic           rx_empty, rx_full, rx_push, rx_pop;

  logic [DB-1:0]  tx_mem [TxDepth];
  logic [TAW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [TAW:0]   txf_cnt_q, txf_cnt_d;
  logic           tx_empty, tx_full, tx_push;

  state_e        tx_st_q;
  logic [16:0]   tx_clk_q;
  logic [15:0]   tx_div_q;
  logic [DB-1:0] tx_shift_q;
  logic [2:0]    tx_idx_q;
  logic          tx_line_q, tx_bit_end, tx_stop_end, tx_start, tx_idle;

  state_e        rx_st_q;
  logic [15:0]   rx_clk_q, rx_div_q;
  logic [DB-1:0] rx_shift_q;
  logic [2:0]    rx_idx_q;
  logic          rx_s1_q, rx_s2_q, rx_prev_q, rx_in, rx_fall;
  logic          rx_half_end, rx_bit_end, rx_stop_done, rx_byte_vld;

  assign lpbk     = ctrl_q[4];
  assign rx_in    = lpbk ? tx_line_q : rx_sig;
  assign tx_sig   = lpbk ? 1'b1 : tx_line_q;
  assign data     = data_q;
  assign irq      = irq_q;
  assign eff_div  = (div_q < 16'd4) ? 16'd4 : div_q;

  assign sel_stat = addr_strobe && addr == 4'h0;
  assign sel_rxd  = addr_strobe && addr == 4'h1;
  assign sel_txd  = addr_strobe && addr == 4'h2;

  assign rx_empty = rxf_cnt_q == '0;
  assign rx_full  = rxf_cnt_q == (RAW+1)'(RxDepth);
  assign tx_empty = txf_cnt_q == '0;
  assign tx_full  = txf_cnt_q == (TAW+1)'(TxDepth);
  assign tx_idle  = tx_empty && tx_st_q == S_IDLE;
  assign status   = {2'b00, rx_full, frame_err_q, overrun_q, tx_idle, ~tx_full, ~rx_empty};

  // A pop in the same cycle frees the slot the incoming byte needs.
  assign rx_pop   = sel_rxd && !rx_empty;
  assign rx_push  = rx_byte_vld && (!rx_full || rx_pop);
  assign tx_push  = sel_txd && !tx_full;

  assign tx_bit_end  = tx_clk_q == {1'b0, tx_div_q} - 17'd1;
  assign tx_stop_end = tx_clk_q == 17'(StopBitsSize) * {1'b0, tx_div_q} - 17'd1;
  assign tx_start    = ctrl_q[1] && !tx_empty &&
                       (tx_st_q == S_IDLE || (tx_st_q == S_STOP && tx_stop_end));

  assign rx_fall      = rx_prev_q && !rx_s2_q;
  assign rx_half_end  = rx_clk_q == (rx_div_q >> 1) - 16'd1;
  assign rx_bit_end   = rx_clk_q == rx_div_q - 16'd1;
  assign rx_stop_done = rx_st_q == S_STOP && rx_bit_end;
  assign rx_byte_vld  = rx_stop_done && rx_s2_q;

  // Every strobe is both a read and a write: software hands back in wdata what it wants kept.
  always_comb begin
    rd_val = 8'h00;
    case (addr)
      4'h0:    rd_val = status;
      4'h1:    rd_val = rx_empty ? 8'h00 : 8'(rx_mem[rx_rp_q]);
      4'h3:    rd_val = div_q[7:0];
      4'h4:    rd_val = div_q[15:8];
      4'h5:    rd_val = {3'b000, ctrl_q};
      default: rd_val = 8'h00;
    endcase
    data_d = addr_strobe ? rd_val : data_q;
    div_d  = div_q;
    if (addr_strobe && addr == 4'h3) div_d[7:0]  = wdata;
    if (addr_strobe && addr == 4'h4) div_d[15:8] = wdata;
    ctrl_d = (addr_strobe && addr == 4'h5) ? (wdata[4:0] & CtrlMask) : ctrl_q;
    overrun_d   = (overrun_q && !(sel_stat && wdata[3])) || (rx_byte_vld && rx_full && !rx_pop);
    frame_err_d = (frame_err_q && !(sel_stat && wdata[4])) || (rx_stop_done && !rx_s2_q);
    irq_d = (ctrl_q[2] && (!rx_empty || overrun_q || frame_err_q)) || (ctrl_q[3] && tx_idle);
  end

  always_comb begin
    rx_wp_d   = rx_push ? rx_wp_q + RAW'(1) : rx_wp_q;
    rx_rp_d   = rx_pop  ? rx_rp_q + RAW'(1) : rx_rp_q;
    rxf_cnt_d = rxf_cnt_q;
    if (rx_push && !rx_pop)      rxf_cnt_d = rxf_cnt_q + (RAW+1)'(1);
    else if (!rx_push && rx_pop) rxf_cnt_d = rxf_cnt_q - (RAW+1)'(1);
    tx_wp_d   = tx_push  ? tx_wp_q + TAW'(1) : tx_wp_q;
    tx_rp_d   = tx_start ? tx_rp_q + TAW'(1) : tx_rp_q;
    txf_cnt_d = txf_cnt_q;
    if (tx_push && !tx_start)      txf_cnt_d = txf_cnt_q + (TAW+1)'(1);
    else if (!tx_push && tx_start) txf_cnt_d = txf_cnt_q - (TAW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DivRst;       ctrl_q <= 5'h03;     data_q <= 8'h00;
      overrun_q <= 1'b0;     frame_err_q <= 1'b0; irq_q <= 1'b0;
      rx_wp_q <= '0;         rx_rp_q <= '0;       rxf_cnt_q <= '0;
      tx_wp_q <= '0;         tx_rp_q <= '0;       txf_cnt_q <= '0;
    end else begin
      div_q <= div_d;        ctrl_q <= ctrl_d;    data_q <= data_d;
      overrun_q <= overrun_d; frame_err_q <= frame_err_d; irq_q <= irq_d;
      rx_wp_q <= rx_wp_d;    rx_rp_q <= rx_rp_d;  rxf_cnt_q <= rxf_cnt_d;
      tx_wp_q <= tx_wp_d;    tx_rp_q <= tx_rp_d;  txf_cnt_q <= txf_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp_q] <= rx_shift_q;
    if (tx_push) tx_mem[tx_wp_q] <= wdata[DB-1:0];
  end

  // TX engine; a frame ending in STOP chains straight into the next START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q <= S_IDLE; tx_clk_q <= '0; tx_div_q <= DivRst;
      tx_shift_q <= '0;  tx_idx_q <= '0; tx_line_q <= 1'b1;
    end else begin
      tx_clk_q <= tx_clk_q + 17'd1;
      case (tx_st_q)
        S_START: if (tx_bit_end) begin
          tx_st_q <= S_DATA; tx_clk_q <= '0; tx_idx_q <= '0; tx_line_q <= tx_shift_q[0];
        end
        S_DATA: if (tx_bit_end) begin
          tx_clk_q <= '0;
          if (tx_idx_q == LastBit) begin
            tx_st_q <= S_STOP; tx_line_q <= 1'b1;
          end else begin
            tx_idx_q <= tx_idx_q + 3'd1; tx_shift_q <= tx_shift_q >> 1; tx_line_q <= tx_shift_q[1];
          end
        end
        S_STOP: if (tx_stop_end) begin
          tx_st_q <= S_IDLE; tx_clk_q <= '0;
        end
        default: ;
      endcase
      if (tx_start) begin
        tx_st_q <= S_START; tx_clk_q <= '0; tx_line_q <= 1'b0;
        tx_shift_q <= tx_mem[tx_rp_q]; tx_div_q <= eff_div;
      end
    end
  end

  // RX engine; rx_en only gates leaving IDLE, so a running frame always completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
      rx_st_q <= S_IDLE; rx_clk_q <= '0; rx_div_q <= DivRst;
      rx_shift_q <= '0; rx_idx_q <= '0;
    end else begin
      rx_s1_q <= rx_in; rx_s2_q <= rx_s1_q; rx_prev_q <= rx_s2_q;
      rx_clk_q <= rx_clk_q + 16'd1;
      case (rx_st_q)
        S_IDLE: if (ctrl_q[0] && rx_fall) begin
          rx_st_q <= S_START; rx_clk_q <= '0; rx_div_q <= eff_div;
        end
        S_START: if (rx_half_end) begin
          rx_clk_q <= '0; rx_idx_q <= '0;
          rx_st_q  <= rx_s2_q ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_bit_end) begin
          rx_clk_q   <= '0;
          rx_shift_q <= {rx_s2_q, rx_shift_q[DB-1:1]};
          if (rx_idx_q == LastBit) rx_st_q <= S_STOP;
          else                     rx_idx_q <= rx_idx_q + 3'd1;
        end
        S_STOP: if (rx_bit_end) begin
          rx_st_q <= S_IDLE; rx_clk_q <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_ctrl_v2.sv
// Directed + randomized bench for uart_ctrl_v2 at DIV=10; expected bytes and waveforms come from a queue model.
module tb_uart_ctrl_v2;
  logic       clk = 1'b0, rst_n = 1'b0, rx_sig = 1'b1, addr_strobe = 1'b0;
  logic [3:0] addr = 4'h0;
  logic [7:0] wdata = 8'h00;
  logic       tx_sig, irq;
  logic [7:0] data;

  int n_chk = 0, n_fail = 0;
  logic rec = 1'b0;
  logic tx_tr[$];
  logic irq_tr[$];

  uart_ctrl_v2 #(.ClockFreqHz(10000000), .BaudRate(1000000), .DataBitsSize(8),
                 .StopBitsSize(1), .RxDepth(16), .TxDepth(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_sig(rx_sig), .tx_sig(tx_sig), .addr(addr),
    .wdata(wdata), .data(data), .addr_strobe(addr_strobe), .irq(irq));

  always #5 clk = ~clk;

  always @(negedge clk) if (rec) begin
    tx_tr.push_back(tx_sig);
    irq_tr.push_back(irq);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [3:0] a, input logic [7:0] w, output logic [7:0] r);
    @(negedge clk); addr = a; wdata = w; addr_strobe = 1'b1;
    @(negedge clk); addr_strobe = 1'b0; r = data;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] w, input logic [7:0] exp);
    logic [7:0] r;
    bus(a, w, r);
    chk(tag, r, exp);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop, input int bt);
    rx_sig = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_sig = b[i];
      repeat (bt) @(negedge clk);
    end
    rx_sig = stop;
    repeat (bt) @(negedge clk);
    rx_sig = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] r, b;
    logic [7:0] q[$];
    logic [7:0] txb[2];
    int f, mism, ones, cnt, seen;
    logic e;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_sig", tx_sig, 1);
    chk("rst_irq", irq, 0);
    chk("rst_data", data, 8'h00);
    rst_n = 1'b1;
    rd_chk("rst_div_lo", 4'h3, 8'h0A, 8'h0A);
    rd_chk("rst_div_hi", 4'h4, 8'h00, 8'h00);
    rd_chk("rst_ctrl", 4'h5, 8'h03, 8'h03);
    rd_chk("rst_status", 4'h0, 8'h00, 8'h06);
    rd_chk("unmapped_rd", 4'h9, 8'hFF, 8'h00);

    // TX back-to-back frames; irq_tx_en shows the exact idle point
    bus(4'h5, 8'h0B, r);
    txb[0] = 8'h55; txb[1] = 8'hA3;
    rec = 1'b1;
    bus(4'h2, txb[0], r);
    bus(4'h2, txb[1], r);
    repeat (240) @(negedge clk);
    rec = 1'b0;
    f = -1;
    foreach (tx_tr[i]) if (f < 0 && tx_tr[i] == 1'b0) f = i;
    chk("tx_start_seen", f >= 0, 1);
    if (f >= 0) begin
      for (int fr = 0; fr < 2; fr++) begin
        mism = 0;
        for (int j = 0; j < 100; j++) begin
          e = (j < 10) ? 1'b0 : (j < 90) ? txb[fr][(j - 10) / 10] : 1'b1;
          if (f + fr * 100 + j >= tx_tr.size() || tx_tr[f + fr * 100 + j] !== e) mism++;
        end
        chk($sformatf("tx_frame%0d_mismatches", fr), mism, 0);
      end
      ones = 0;
      for (int j = 0; j <= 200; j++) if (f + j < irq_tr.size() && irq_tr[f + j] !== 1'b0) ones++;
      chk("tx_busy_irq", ones, 0);
      chk("tx_idle_edge", (f + 201 < irq_tr.size()) ? irq_tr[f + 201] : 1'bx, 1);
    end
    bus(4'h5, 8'h03, r);
    chk("ctrl_readback", r, 8'h0B);

    // RX of 0x3C with TX held busy (tx_en=0, one byte queued)
    bus(4'h5, 8'h01, r);
    bus(4'h2, 8'h99, r);
    rx_frame(8'h3C, 1'b1, 10);
    rd_chk("rx_status_avail", 4'h0, 8'h00, 8'h03);
    rd_chk("rx_byte_3c", 4'h1, 8'h00, 8'h3C);
    rd_chk("rx_status_empty", 4'h0, 8'h00, 8'h02);
    bus(4'h5, 8'h03, r);
    repeat (120) @(negedge clk);
    rd_chk("tx_drained", 4'h0, 8'h00, 8'h06);

    // randomized RX bursts against a queue model
    for (int round = 0; round < 3; round++) begin
      cnt = $urandom_range(1, 5);
      for (int k = 0; k < cnt; k++) begin
        b = 8'($urandom);
        rx_frame(b, 1'b1, 10);
        q.push_back(b);
        repeat ($urandom_range(0, 7)) @(negedge clk);
      end
      while (q.size() > 0) rd_chk("rx_rand_pop", 4'h1, 8'h00, q.pop_front());
      rd_chk("rx_rand_status", 4'h0, 8'h00, 8'h06);
    end

    // overrun: 17 frames into a 16-deep FIFO
    for (int k = 0; k < 17; k++) begin
      b = 8'($urandom);
      rx_frame(b, 1'b1, 10);
      if (q.size() < 16) q.push_back(b);
    end
    rd_chk("ovr_status", 4'h0, 8'h00, 8'h2F);
    while (q.size() > 0) rd_chk("ovr_pop", 4'h1, 8'h00, q.pop_front());
    rd_chk("empty_pop", 4'h1, 8'h00, 8'h00);
    rd_chk("ovr_clear", 4'h0, 8'h08, 8'h0E);
    rd_chk("ovr_cleared", 4'h0, 8'h00, 8'h06);

    // framing error and glitch rejection
    rx_frame(8'($urandom), 1'b0, 10);
    rd_chk("ferr_status", 4'h0, 8'h00, 8'h16);
    rd_chk("ferr_clear", 4'h0, 8'h10, 8'h16);
    rd_chk("ferr_cleared", 4'h0, 8'h00, 8'h06);
    rx_sig = 1'b0;
    repeat (3) @(negedge clk);
    rx_sig = 1'b1;
    repeat (30) @(negedge clk);
    rd_chk("glitch_status", 4'h0, 8'h00, 8'h06);

    // RX interrupt
    bus(4'h5, 8'h07, r);
    repeat (2) @(negedge clk);
    chk("irq_quiet", irq, 0);
    b = 8'($urandom);
    rx_frame(b, 1'b1, 10);
    chk("irq_rx", irq, 1);
    rd_chk("irq_rx_byte", 4'h1, 8'h00, b);
    repeat (2) @(negedge clk);
    chk("irq_rx_clear", irq, 0);
    bus(4'h5, 8'h03, r);

    // divisor below the floor runs at 4 clocks per bit
    bus(4'h3, 8'h02, r);
    rd_chk("div_lo_wr", 4'h3, 8'h02, 8'h02);
`ifdef UART_LOOPBACK_EN
    bus(4'h5, 8'h13, r);
    rd_chk("ctrl_lpbk", 4'h5, 8'h13, 8'h13);
    tx_tr.delete();
    rec = 1'b1;
    bus(4'h2, 8'h81, r);
    repeat (70) @(negedge clk);
    rec = 1'b0;
    ones = 0;
    foreach (tx_tr[i]) if (tx_tr[i] === 1'b1) ones++;
    chk("lpbk_tx_high", ones, tx_tr.size());
    rd_chk("lpbk_byte", 4'h1, 8'h00, 8'h81);
    bus(4'h5, 8'h03, r);
`else
    bus(4'h5, 8'h13, r);
    rd_chk("ctrl_no_lpbk", 4'h5, 8'h03, 8'h03);
    b = 8'($urandom);
    rx_frame(b, 1'b1, 4);
    rd_chk("div4_byte", 4'h1, 8'h00, b);
`endif

    // reset in the middle of a TX frame
    bus(4'h2, 8'h00, r);
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      @(negedge clk);
      if (tx_sig === 1'b0) seen = 1;
    end
    chk("midrst_frame_seen", seen, 1);
    #2 rst_n = 1'b0;
    #1 chk("midrst_tx_high", tx_sig, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_chk("midrst_div", 4'h3, 8'h0A, 8'h0A);
    rd_chk("midrst_status", 4'h0, 8'h00, 8'h06);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
